// File: rtl/usb_uart_loopback_fifo.sv
// Loopback engine for the USB CDC UART streams.
// Host bytes pass through a DEPTH-entry FIFO and back to the host. A runtime
// mode selects plain echo, echo with CR -> CR/LF expansion, a counting test
// pattern, or sink. Stretched activity strobes and a received-byte counter
// are provided for the LED driver and for debug.
module usb_uart_loopback_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int STRETCH = 2400000
) (
  input  logic                     clk_48mhz,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     rx_led,
  output logic                     tx_led,
  output logic [15:0]              rx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STRETCH + 1);

  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0]    LED_LOAD = CW'(STRETCH);
  localparam logic [WIDTH-1:0] CHAR_CR  = WIDTH'(8'h0D);
  localparam logic [WIDTH-1:0] CHAR_LF  = WIDTH'(8'h0A);

  localparam logic [1:0] MODE_ECHO = 2'd0;
  localparam logic [1:0] MODE_LF   = 2'd1;
  localparam logic [1:0] MODE_PAT  = 2'd2;

  typedef enum logic {S_IDLE, S_INSERT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [LW-1:0]      level_q;
  logic [WIDTH-1:0]   pat;
  logic [15:0]        rx_count_q;
  logic [CW-1:0]      rx_led_cnt, tx_led_cnt;

  logic               full, empty;
  logic               wr_en, pat_wr;
  logic [WIDTH-1:0]   wr_data;
  logic               rx_fire, tx_fire;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign level    = level_q;
  assign rx_count = rx_count_q;
  assign rx_led   = (rx_led_cnt != '0);
  assign tx_led   = (tx_led_cnt != '0);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  // LF-insert state register
  always_ff @(posedge clk_48mhz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: a pending LF always finishes first, whatever the mode now is
  always_comb begin
    state_nxt = state;
    if (state == S_INSERT) begin
      if (!full) state_nxt = S_IDLE;
    end else if (mode == MODE_LF && rx_fire && rx_data == CHAR_CR) begin
      state_nxt = S_INSERT;
    end
  end

  // Write source and rx handshake; rx_ready never looks at rx_valid
  always_comb begin
    rx_ready = 1'b0;
    wr_en    = 1'b0;
    pat_wr   = 1'b0;
    wr_data  = rx_data;
    if (!reset) begin
      if (state == S_INSERT) begin
        wr_en   = !full;
        wr_data = CHAR_LF;
      end else begin
        case (mode)
          MODE_ECHO, MODE_LF: begin
            rx_ready = !full;
            wr_en    = rx_valid && !full;
          end
          MODE_PAT: begin
            rx_ready = 1'b1;
            wr_en    = !full;
            pat_wr   = !full;
            wr_data  = pat;
          end
          default: begin
            rx_ready = 1'b1;
          end
        endcase
      end
    end
  end

  // FIFO storage; data is not reset, validity comes from level
  always_ff @(posedge clk_48mhz) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
      if (tx_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, tx_fire})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Pattern generator restarts at zero on every entry into pattern mode
  always_ff @(posedge clk_48mhz) begin
    if (reset || mode != MODE_PAT) pat <= '0;
    else if (pat_wr)               pat <= pat + WIDTH'(1);
  end

  // Received-byte counter, counts discarded bytes too
  always_ff @(posedge clk_48mhz) begin
    if (reset)        rx_count_q <= '0;
    else if (rx_fire) rx_count_q <= rx_count_q + 16'd1;
  end

  // Activity strobe stretchers
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rx_led_cnt <= '0;
      tx_led_cnt <= '0;
    end else begin
      if (rx_fire)                rx_led_cnt <= LED_LOAD;
      else if (rx_led_cnt != '0)  rx_led_cnt <= rx_led_cnt - CW'(1);
      if (tx_fire)                tx_led_cnt <= LED_LOAD;
      else if (tx_led_cnt != '0)  tx_led_cnt <= tx_led_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_usb_uart_loopback_fifo.sv
// Scoreboard bench for usb_uart_loopback_fifo: the stimulus side predicts the
// byte stream the host should see back, a monitor pops and compares on every
// tx transfer.
module tb_usb_uart_loopback_fifo;

  localparam int W = 8;
  localparam int D = 16;
  localparam int S = 8;

  logic           clk_48mhz = 1'b0;
  logic           reset;
  logic [1:0]     mode;
  logic [W-1:0]   rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [4:0]     level;
  logic           rx_led;
  logic           tx_led;
  logic [15:0]    rx_count;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_loopback_fifo #(.WIDTH(W), .DEPTH(D), .STRETCH(S)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .mode      (mode),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .level     (level),
    .rx_led    (rx_led),
    .tx_led    (tx_led),
    .rx_count  (rx_count)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];
  int          tx_mode = 1;     // 0: always ready, 1: never ready, 2: random
  int          pops = 0;
  int          peak = 0;
  logic [15:0] rx_model = 16'd0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: choose tx_ready for the coming edge, then check any pop it causes
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk_48mhz);
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        default: tx_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (int'(level) > peak) peak = int'(level);
      if (tx_valid && tx_ready && !reset) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got byte %0d expected none", tx_data);
        end else begin
          chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Offer one byte and wait (bounded) for acceptance; record the prediction
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_48mhz);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 300) begin
      @(negedge clk_48mhz);
      n++;
    end
    if (!rx_ready) begin
      fail_now("rx_accept_timeout");
    end else begin
      rx_model = rx_model + 16'd1;
      if (mode == 2'd0 || mode == 2'd1) exp_q.push_back(b);
      if (mode == 2'd1 && b == 8'h0D)   exp_q.push_back(8'h0A);
    end
  endtask

  task automatic idle();
    @(negedge clk_48mhz);
    rx_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (level != '0 && n < 2000) begin
      @(negedge clk_48mhz);
      n++;
    end
    if (level != '0) fail_now("drain_timeout");
  endtask

  task automatic run_pattern(input int npop, input int npush);
    int p0, n;
    exp_q.delete();
    for (int i = 0; i < npush; i++) exp_q.push_back(8'(i));
    @(negedge clk_48mhz);
    mode = 2'd2;
    p0 = pops;
    n = 0;
    while (pops - p0 < npop && n < 3000) begin
      @(negedge clk_48mhz);
      n++;
    end
    mode = 2'd3;
    wait_empty();
    chk("pattern_pops_reached", int'(pops - p0 >= npop), 1);
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    mode     = 2'd0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk_48mhz);
    chk("reset_tx_valid", int'(tx_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_rx_led", int'(rx_led), 0);
    chk("reset_tx_led", int'(tx_led), 0);
    chk("reset_rx_count", int'(rx_count), 0);
    chk("reset_rx_ready", int'(rx_ready), 0);
    reset = 1'b0;

    // Strobe length: one sunk byte, no tx activity
    mode = 2'd3;
    send(8'h55);
    idle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_led) cnt++;
      @(negedge clk_48mhz);
    end
    chk("rx_led_cycles", cnt, S);
    chk("tx_led_quiet", int'(tx_led), 0);
    chk("rx_count_sink1", int'(rx_count), int'(rx_model));

    // Echo with host always ready
    mode = 2'd0;
    tx_mode = 0;
    @(negedge clk_48mhz);
    peak = 0;
    send(8'h41);
    idle();
    chk("latency_tx_valid", int'(tx_valid), 1);
    chk("latency_tx_data", int'(tx_data), 8'h41);
    send(8'h42);
    send(8'h43);
    idle();
    repeat (3) @(negedge clk_48mhz);
    chk("echo_peak_level", peak, 1);
    chk("echo_rx_count", int'(rx_count), int'(rx_model));
    chk("echo_queue_empty", exp_q.size(), 0);

    // Fill to full with host stalled, then drain
    tx_mode = 1;
    @(negedge clk_48mhz);
    for (int i = 0; i < D; i++) send(8'(8'h10 + i));
    @(negedge clk_48mhz);
    rx_valid = 1'b1;
    rx_data  = 8'h20;
    chk("full_rx_ready", int'(rx_ready), 0);
    chk("full_level", int'(level), D);
    tx_mode = 0;
    send(8'h20);
    send(8'h21);
    idle();
    wait_empty();
    chk("full_queue_empty", exp_q.size(), 0);

    // CR expansion
    mode = 2'd1;
    send(8'h68);
    send(8'h0D);
    @(negedge clk_48mhz);
    rx_valid = 1'b0;
    chk("insert_rx_ready_low", int'(rx_ready), 0);
    @(negedge clk_48mhz);
    chk("insert_rx_ready_back", int'(rx_ready), 1);
    send(8'h69);
    idle();
    wait_empty();
    repeat (2) @(negedge clk_48mhz);
    chk("lf_queue_empty", exp_q.size(), 0);
    chk("lf_rx_count", int'(rx_count), int'(rx_model));

    // Pattern: 300 bytes, then leave and re-enter to see it restart at zero
    tx_mode = 0;
    run_pattern(300, 330);
    mode = 2'd0;
    @(negedge clk_48mhz);
    tx_mode = 2;
    run_pattern(40, 64);

    // Sink drains buffered bytes while swallowing rx
    mode = 2'd0;
    tx_mode = 1;
    @(negedge clk_48mhz);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
    idle();
    chk("sink_prefill_level", int'(level), 5);
    mode = 2'd3;
    tx_mode = 2;
    for (int i = 0; i < 10; i++) send(8'($urandom));
    idle();
    chk("sink_rx_count", int'(rx_count), int'(rx_model));
    wait_empty();
    @(negedge clk_48mhz);
    chk("sink_tx_valid", int'(tx_valid), 0);
    chk("sink_queue_empty", exp_q.size(), 0);

    // Randomised traffic across echo, CR expansion and sink modes
    mode = 2'd0;
    tx_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        idle();
        case ($urandom_range(0, 2))
          0:       mode = 2'd0;
          1:       mode = 2'd1;
          default: mode = 2'd3;
        endcase
      end
      if ($urandom_range(0, 2) == 0) idle();
      send(($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom));
    end
    idle();
    wait_empty();
    repeat (3) @(negedge clk_48mhz);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_rx_count", int'(rx_count), int'(rx_model));

    // Reset while an LF is pending with four bytes buffered
    mode = 2'd1;
    tx_mode = 1;
    @(negedge clk_48mhz);
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h0D);
    @(negedge clk_48mhz);
    rx_valid = 1'b0;
    chk("pre_reset_level", int'(level), 4);
    chk("pre_reset_insert", int'(rx_ready), 0);
    reset = 1'b1;
    @(negedge clk_48mhz);
    chk("mid_reset_level", int'(level), 0);
    chk("mid_reset_tx_valid", int'(tx_valid), 0);
    chk("mid_reset_rx_led", int'(rx_led), 0);
    chk("mid_reset_tx_led", int'(tx_led), 0);
    chk("mid_reset_rx_count", int'(rx_count), 0);
    chk("mid_reset_rx_ready", int'(rx_ready), 0);
    exp_q.delete();
    rx_model = 16'd0;
    reset = 1'b0;
    mode = 2'd0;
    tx_mode = 2;
    repeat (30) @(negedge clk_48mhz);
    chk("post_reset_level", int'(level), 0);
    chk("post_reset_tx_valid", int'(tx_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
